// File: rtl/circuit6_seq.sv
// rtl/circuit6_seq.sv - sequential z = ((a mod c) == zero) ? c+1 : a-1 using a bit-serial restoring remainder
module circuit6_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] zero,
    output logic                 busy,
    output logic                 done,
    output logic                 divzero,
    output logic [DATAWIDTH-1:0] z
);

    localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] c_q, c_d;
    logic [DATAWIDTH-1:0] zero_q, zero_d;
    logic [DATAWIDTH-1:0] rem_q, rem_d;
    logic [DATAWIDTH-1:0] z_q, z_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 divzero_q, divzero_d;

    // Shifted partial remainder is one bit wider so the compare against c never overflows.
    logic [DATAWIDTH:0]   rem_shift;
    logic                 rem_ge;

    always_comb begin
        rem_shift = {rem_q, a_q[cnt_q]};
        rem_ge    = (rem_shift >= {1'b0, c_q});

        state_d   = state_q;
        a_d       = a_q;
        c_d       = c_q;
        zero_d    = zero_q;
        rem_d     = rem_q;
        z_d       = z_q;
        cnt_d     = cnt_q;
        divzero_d = divzero_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle sits in IDLE; a start coinciding with it is dropped.
                if (start && !done_q) begin
                    a_d    = a;
                    c_d    = c;
                    zero_d = zero;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (c != '0) begin
                        cnt_d   = CW'(DATAWIDTH - 1);
                        state_d = DIV;
                    end else begin
                        rem_d   = a;
                        state_d = CMP;
                    end
                end
            end
            DIV: begin
                if (rem_ge) begin
                    rem_d = rem_shift[DATAWIDTH-1:0] - c_q;
                end else begin
                    rem_d = rem_shift[DATAWIDTH-1:0];
                end
                if (cnt_q == '0) begin
                    state_d = CMP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CMP: begin
                if (rem_q == zero_q) begin
                    z_d = c_q + DATAWIDTH'(1);
                end else begin
                    z_d = a_q - DATAWIDTH'(1);
                end
                divzero_d = (c_q == '0);
                state_d   = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            c_q       <= '0;
            zero_q    <= '0;
            rem_q     <= '0;
            z_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            c_q       <= c_d;
            zero_q    <= zero_d;
            rem_q     <= rem_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign divzero = divzero_q;
    assign z       = z_q;

endmodule

// File: doc/circuit6_seq.md
CIRCUIT6_SEQ -- requirements
Module: circuit6_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 64: width of all operands and the result.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port a  input  DATAWIDTH  dividend operand, unsigned.
REQ-006 SHALL have port c  input  DATAWIDTH  divisor operand, unsigned.
REQ-007 SHALL have port zero  input  DATAWIDTH  compare constant for the remainder.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when z is updated.
REQ-010 SHALL have port divzero  output  1  set with done when the latched c was 0.
REQ-011 SHALL have port z  output  DATAWIDTH  registered result.

Function
REQ-012 SHALL compute z = ((a mod c) == zero) ? (c + 1) : (a - 1), using operands latched at start acceptance.
REQ-013 SHALL replace the combinational modulo with one shared iterative restoring-remainder unit that resolves one dividend bit per cycle, MSB first.
REQ-014 SHALL implement FSM states IDLE, DIV, CMP, DONE.
REQ-015 IDLE, start=1: SHALL latch a, c and zero, and clear the remainder. If latched c != 0, SHALL load bit counter = DATAWIDTH-1 and go to DIV. If latched c == 0, SHALL go to CMP.
REQ-016 IDLE, start=0: SHALL remain in IDLE.
REQ-017 DIV SHALL last exactly DATAWIDTH cycles. Each cycle:
- rem = {rem, next a bit};
- if rem >= c, subtract c;
- on counter 0, go to CMP.
REQ-018 CMP (1 cycle): SHALL register z = c+1 if rem == zero, else a-1, then go to DONE.
REQ-019 DONE (1 cycle): SHALL assert done, then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following the (DATAWIDTH+2)th rising edge after the start-accepting edge when c != 0, and following the 2nd edge when c == 0.
REQ-021 Divide by zero: remainder SHALL be defined as a, and divzero SHALL be 1 for that result. Otherwise divzero SHALL be 0 and is updated with each z.
REQ-022 Arithmetic SHALL be modulo 2^DATAWIDTH:
- a-1 with a=0 wraps to all-ones;
- c+1 with c=all-ones wraps to 0.
- The remainder path SHALL carry one extra bit so that the shift-then-compare does not overflow.
REQ-023 start while busy SHALL be ignored, with no queuing and no effect on the latched operands.
REQ-024 Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 z and divzero SHALL hold their last values between done pulses.
REQ-026 start sampled in the same cycle that done is high SHALL be ignored. The earliest new acceptance is the cycle after done.

Reset
REQ-027 Rst=1 at a rising edge SHALL force:
- state IDLE;
- busy=0, done=0, divzero=0;
- z=0, remainder=0, counter=0.
REQ-028 Rst asserted mid-operation SHALL abort the operation with no done pulse. The first start after Rst deasserts SHALL be accepted normally.
REQ-029 Rst SHALL take priority over start on the same edge.

Verification (DATAWIDTH=8)
REQ-030 a=10, c=5, zero=0, start pulse -> done after 10 edges, z=6, divzero=0.
REQ-031 a=10, c=3, zero=0 -> rem=1, z=9. Then a=0, c=3, zero=5 -> z=0xFF (wrap).
REQ-032 a=0, c=0xFF, zero=0 -> rem=0, z=0x00 (c+1 wrap); a=0xFF, c=0x10, zero=0x0F -> z=0x11.
REQ-033 a=7, c=0, zero=7 -> done after 2 edges, z=1, divzero=1. Next op a=9, c=2, zero=1 -> z=3, divzero=0.
REQ-034 Pulse start at cycles +1, +5 and on the done cycle during an op with a=10, c=5, zero=0 -> exactly one done, z=6, and busy stays high for the full operation.
REQ-035 Assert Rst at the 4th DIV cycle -> next edge busy=0, z=0, no done. A following start with a=10, c=3, zero=0 -> z=9.
